sha256_block_sequencer: RTL

//  Upstream feeder for simplified_sha256. Reads an N-word message from word-addressed memory and

---
 rtl/sha256_pkg.sv | 47 ++++
 rtl/sha256_block_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: initial hash, round constants, word/block/hash types,
// the sequencer state encoding and the message padding rule.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] block_t;
  typedef word_t [7:0] hash_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_KICK      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_t;

  // Concatenation lists H7 first so that index 0 holds the first digest word.
  localparam hash_t H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Word g of the padded stream; n is its position inside the block.
  function automatic word_t pad_word(input logic [15:0] g, input logic [3:0] n,
                                     input logic [15:0] len_words, input logic is_last,
                                     input word_t rdata);
    word_t bit_len;
    bit_len = {11'd0, len_words, 5'd0};
    if (g < len_words)                 return rdata;
    else if (g == len_words)           return 32'h80000000;
    else if (is_last && n == 4'd15)    return bit_len;
    else                               return 32'h0;
  endfunction

endpackage

// File: rtl/sha256_block_sequencer.sv
// Reads a message from word memory, builds padded 512-bit blocks and runs the
// compression core once per block, chaining digests, then presents the final hash.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter logic [15:0] MAX_WORDS = 16'd1024,
  parameter int          ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [15:0]       message_size,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  word_t             mem_rdata,
  output logic              core_start,
  input  logic              core_done,
  output block_t            core_message,
  output hash_t             core_input_hash,
  input  hash_t             core_output_hash,
  output logic              busy,
  output logic              done,
  output hash_t             digest,
  output seq_state_t        state_dbg
);

  // Handshakes: start is sampled only in IDLE. mem_re/mem_addr are registered and
  // mem_rdata is taken one cycle after the strobe is seen. core_start is a one-cycle
  // pulse; core_done low means the core has taken the block, high again means
  // core_output_hash is valid. done is a one-cycle pulse with digest valid alongside.

  seq_state_t        state;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       len_words;
  logic [15:0]       nb;
  logic [15:0]       blk;
  logic [3:0]        fill_n;
  logic              drain;
  logic [3:0]        rd_n;
  logic              rd_valid;
  logic [3:0]        rd_idx;

  logic [15:0] blk_base;
  logic [15:0] g;
  logic        is_last;
  logic        blk_reads;
  logic        word_reads;
  logic [15:0] size_clamped;
  logic [15:0] nb_calc;

  always_comb begin
    blk_base     = blk << 4;
    g            = blk_base + {12'd0, fill_n};
    is_last      = (blk + 16'd1) == nb;
    blk_reads    = blk_base < len_words;
    word_reads   = g < len_words;
    size_clamped = (message_size > MAX_WORDS) ? MAX_WORDS : message_size;
    // Words 14/15 of the last block carry the length, so a tail of 14+ words spills.
    nb_calc      = (size_clamped >> 4) + ((size_clamped[3:0] < 4'd14) ? 16'd1 : 16'd2);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      base_addr       <= '0;
      len_words       <= '0;
      nb              <= '0;
      blk             <= '0;
      fill_n          <= '0;
      drain           <= 1'b0;
      rd_n            <= '0;
      rd_valid        <= 1'b0;
      rd_idx          <= '0;
      mem_re          <= 1'b0;
      mem_addr        <= '0;
      core_start      <= 1'b0;
      core_message    <= '0;
      core_input_hash <= H0;
      busy            <= 1'b0;
      done            <= 1'b0;
      digest          <= '0;
    end else begin
      mem_re     <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      // Read return: the strobe was registered last cycle, data arrives this cycle.
      rd_valid   <= mem_re;
      rd_idx     <= rd_n;
      if (rd_valid) core_message[rd_idx] <= mem_rdata;

      case (state)
        ST_IDLE: begin
          if (start) begin
            base_addr       <= message_addr;
            len_words       <= size_clamped;
            nb              <= nb_calc;
            blk             <= '0;
            fill_n          <= '0;
            drain           <= 1'b0;
            core_input_hash <= H0;
            busy            <= 1'b1;
            state           <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (drain) begin
            drain <= 1'b0;
            state <= ST_KICK;
          end else begin
            if (word_reads) begin
              mem_re   <= 1'b1;
              mem_addr <= base_addr + ADDR_W'(g);
              rd_n     <= fill_n;
            end else begin
              core_message[fill_n] <= pad_word(g, fill_n, len_words, is_last, 32'h0);
            end
            fill_n <= fill_n + 4'd1;
            if (fill_n == 4'd15) begin
              if (blk_reads) drain <= 1'b1;
              else           state <= ST_KICK;
            end
          end
        end
        ST_KICK: begin
          core_start <= 1'b1;
          state      <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!core_done) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (core_done) begin
            core_input_hash <= core_output_hash;
            blk             <= blk + 16'd1;
            fill_n          <= '0;
            state           <= ((blk + 16'd1) == nb) ? ST_FINISH : ST_LOAD;
          end
        end
        ST_FINISH: begin
          digest <= core_input_hash;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
